// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the MIPS-subset datapath.
// Drives memory req/ack handshakes, all datapath strobes, and a per-handshake ack watchdog.
module cpu_sequencer #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       i_ack,
    input  logic       d_ack,
    output logic       i_req,
    output logic       d_req,
    output logic       d_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_w,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src,
    output logic [2:0] alu_op,
    output logic       retire,
    output logic       trap,
    output logic [1:0] trap_code,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd7
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;

    // Count value on the last wait cycle before a missing ack traps the core.
    localparam logic [7:0] CntLast = 8'(ACK_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] code_q, code_d;
    logic       legal;

    always_comb begin
        unique case (opcode)
            OpRtype, OpAddi, OpLw, OpSw, OpBeq, OpBne, OpJ: legal = 1'b1;
            default:                                        legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        code_d     = code_q;
        i_req      = 1'b0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'b00;
        reg_w      = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 3'b000;
        retire     = 1'b0;

        // Reset masks every strobe combinationally so nothing fires in the reset cycle.
        if (!rst) begin
            unique case (state_q)
                StFetch: begin
                    i_req = 1'b1;
                    if (i_ack) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = StDecode;
                    end else if (cnt_q == CntLast) begin
                        state_d = StTrap;
                        code_d  = 2'b01;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StDecode: begin
                    if (opcode == OpJ) begin
                        pc_we   = 1'b1;
                        pc_src  = 2'b10;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else if (!legal) begin
                        state_d = StTrap;
                        code_d  = 2'b11;
                    end else begin
                        state_d = StExec;
                    end
                end
                StExec: begin
                    unique case (opcode)
                        OpRtype: begin
                            alu_op  = 3'b010;
                            state_d = StWb;
                        end
                        OpAddi: begin
                            alu_src = 1'b1;
                            state_d = StWb;
                        end
                        OpLw, OpSw: begin
                            alu_src = 1'b1;
                            state_d = StMem;
                        end
                        OpBeq, OpBne: begin
                            alu_op = (opcode == OpBne) ? 3'b101 : 3'b001;
                            // bne inverts the sense of the zero flag.
                            if (zero ^ alu_op[2]) begin
                                pc_we  = 1'b1;
                                pc_src = 2'b01;
                            end
                            retire  = 1'b1;
                            state_d = StFetch;
                        end
                        default: begin
                            state_d = StTrap;
                            code_d  = 2'b11;
                        end
                    endcase
                end
                StMem: begin
                    d_req   = 1'b1;
                    d_we    = (opcode == OpSw);
                    alu_src = 1'b1;
                    if (d_ack) begin
                        if (opcode == OpSw) begin
                            retire  = 1'b1;
                            state_d = StFetch;
                        end else begin
                            state_d = StWb;
                        end
                    end else if (cnt_q == CntLast) begin
                        state_d = StTrap;
                        code_d  = 2'b10;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StWb: begin
                    reg_w      = 1'b1;
                    retire     = 1'b1;
                    reg_dst    = (opcode == OpRtype);
                    mem_to_reg = (opcode == OpLw);
                    state_d    = StFetch;
                end
                StTrap: state_d = StTrap;
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            cnt_q   <= '0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    assign trap      = !rst && (state_q == StTrap);
    assign trap_code = rst ? 2'b00 : code_q;
    assign state     = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle hand-computed expectations for each scenario.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       i_ack;
    logic       d_ack;
    logic       i_req, d_req, d_we, ir_we, pc_we;
    logic [1:0] pc_src;
    logic       reg_w, reg_dst, mem_to_reg, alu_src;
    logic [2:0] alu_op;
    logic       retire, trap;
    logic [1:0] trap_code;
    logic [2:0] state;
    logic [20:0] all_outs;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.ACK_TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .zero      (zero),
        .i_ack     (i_ack),
        .d_ack     (d_ack),
        .i_req     (i_req),
        .d_req     (d_req),
        .d_we      (d_we),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .reg_w     (reg_w),
        .reg_dst   (reg_dst),
        .mem_to_reg(mem_to_reg),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .retire    (retire),
        .trap      (trap),
        .trap_code (trap_code),
        .state     (state)
    );

    assign all_outs = {state, i_req, d_req, d_we, ir_we, pc_we, pc_src, reg_w, reg_dst,
                       mem_to_reg, alu_src, alu_op, retire, trap, trap_code};

    // Advance to just after the next rising edge; inputs are then set for the new cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reset edge, then return positioned in the first FETCH cycle.
    task automatic do_reset();
        rst = 1'b1; i_ack = 1'b0; d_ack = 1'b0; zero = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_ack = 1'b1; d_ack = 1'b1; opcode = 6'b000010; zero = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if (all_outs !== 21'd0) begin
                miscompares++;
                $display("FAIL rst_outs cyc%0d: got %h want 000000", c, all_outs);
            end
            next_cycle();
        end
        rst = 1'b0; i_ack = 1'b0; d_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if ({state, i_req, trap} !== {3'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_release: got st=%0d ireq=%b trap=%b want st=0 ireq=1 trap=0",
                     state, i_req, trap);
        end
    endtask

    task automatic test_rtype();
        do_reset();
        opcode = 6'b000000; i_ack = 1'b1;
        @(negedge clk);
        vectors++;
        if ({state, ir_we, pc_we, pc_src} !== {3'd0, 1'b1, 1'b1, 2'b00}) begin
            miscompares++;
            $display("FAIL rtype_fetch: got %b want 0001100", {state, ir_we, pc_we, pc_src});
        end
        next_cycle(); i_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if ({state, pc_we, ir_we} !== {3'd1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL rtype_decode: got %b want 00100", {state, pc_we, ir_we});
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({state, alu_op, alu_src, retire} !== {3'd2, 3'b010, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL rtype_exec: got %b want 01001000", {state, alu_op, alu_src, retire});
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({state, reg_w, reg_dst, mem_to_reg, retire} !== {3'd4, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL rtype_wb: got %b want 1001101",
                     {state, reg_w, reg_dst, mem_to_reg, retire});
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({state, i_req, retire, reg_w} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL rtype_refetch: got %b want 000100", {state, i_req, retire, reg_w});
        end
    endtask

    task automatic test_lw_wait();
        logic [2:0] exp_st [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        int dreq_cycles = 0;
        do_reset();
        opcode = 6'b100011;
        for (int c = 0; c < 8; c++) begin
            i_ack = (c == 0);
            d_ack = (c == 6);
            @(negedge clk);
            if (d_req === 1'b1) dreq_cycles++;
            vectors++;
            if (state !== exp_st[c] || d_we !== 1'b0) begin
                miscompares++;
                $display("FAIL lw_seq cyc%0d: got st=%0d dwe=%b want st=%0d dwe=0",
                         c, state, d_we, exp_st[c]);
            end
            if (c == 2 || (c >= 3 && c <= 6)) begin
                vectors++;
                if ({alu_src, alu_op} !== 4'b1000) begin
                    miscompares++;
                    $display("FAIL lw_addr cyc%0d: got %b want 1000", c, {alu_src, alu_op});
                end
            end
            if (c == 7) begin
                vectors++;
                if ({reg_w, mem_to_reg, reg_dst, retire, d_req} !== 5'b11010) begin
                    miscompares++;
                    $display("FAIL lw_wb: got %b want 11010",
                             {reg_w, mem_to_reg, reg_dst, retire, d_req});
                end
            end
            next_cycle();
        end
        d_ack = 1'b0;
        vectors++;
        if (dreq_cycles !== 4) begin
            miscompares++;
            $display("FAIL lw_dreq_len: got %0d want 4", dreq_cycles);
        end
    endtask

    task automatic test_sw();
        do_reset();
        opcode = 6'b101011; i_ack = 1'b1;
        next_cycle(); i_ack = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({state, d_req, d_we, retire} !== {3'd3, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL sw_wait: got %b want 011110", {state, d_req, d_we, retire});
        end
        next_cycle(); d_ack = 1'b1;
        @(negedge clk);
        vectors++;
        if ({state, d_req, d_we, retire, reg_w} !== {3'd3, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL sw_ack: got %b want 0111110", {state, d_req, d_we, retire, reg_w});
        end
        next_cycle(); d_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if ({state, d_req, i_req} !== {3'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL sw_done: got %b want 00001", {state, d_req, i_req});
        end
    endtask

    // Runs one branch through to EXEC and checks the EXEC-cycle strobes.
    task automatic run_branch(input logic [5:0] op, input logic z, input logic [2:0] exp_op,
                              input logic exp_we, input logic [1:0] exp_src, input string name);
        do_reset();
        opcode = op; zero = z; i_ack = 1'b1;
        next_cycle(); i_ack = 1'b0;
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({state, alu_op, pc_we, pc_src, retire} !== {3'd2, exp_op, exp_we, exp_src, 1'b1}) begin
            miscompares++;
            $display("FAIL %s: got st=%0d op=%b we=%b src=%b ret=%b want st=2 op=%b we=%b src=%b ret=1",
                     name, state, alu_op, pc_we, pc_src, retire, exp_op, exp_we, exp_src);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({state, retire} !== {3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL %s_next: got st=%0d ret=%b want st=0 ret=0", name, state, retire);
        end
    endtask

    task automatic test_branches();
        run_branch(6'b000101, 1'b0, 3'b101, 1'b1, 2'b01, "bne_taken");
        run_branch(6'b000100, 1'b0, 3'b001, 1'b0, 2'b00, "beq_not_taken");
        run_branch(6'b000100, 1'b1, 3'b001, 1'b1, 2'b01, "beq_taken");
        run_branch(6'b000101, 1'b1, 3'b101, 1'b0, 2'b00, "bne_not_taken");
    endtask

    task automatic test_jump();
        do_reset();
        opcode = 6'b000010; i_ack = 1'b1;
        next_cycle(); i_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if ({state, pc_we, pc_src, retire} !== {3'd1, 1'b1, 2'b10, 1'b1}) begin
            miscompares++;
            $display("FAIL j_decode: got %b want 00111101", {state, pc_we, pc_src, retire});
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({state, i_req} !== {3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL j_next: got %b want 0001", {state, i_req});
        end
    endtask

    task automatic test_fetch_watchdog();
        do_reset();
        opcode = 6'b000000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if ({state, i_req, trap} !== {3'd0, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL fwd_wait cyc%0d: got %b want 00010", c, {state, i_req, trap});
            end
            next_cycle();
        end
        i_ack = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if ({state, trap, trap_code, i_req, ir_we} !== {3'd7, 1'b1, 2'b01, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL fwd_trap cyc%0d: got %b want 11110100",
                         c, {state, trap, trap_code, i_req, ir_we});
            end
            next_cycle();
        end
        do_reset();
        for (int c = 0; c < 4; c++) begin
            i_ack = (c == 3);
            @(negedge clk);
            next_cycle();
        end
        i_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if ({state, trap} !== {3'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL fwd_boundary: got st=%0d trap=%b want st=1 trap=0", state, trap);
        end
    endtask

    task automatic test_data_watchdog();
        do_reset();
        opcode = 6'b100011; i_ack = 1'b1;
        next_cycle(); i_ack = 1'b0;
        next_cycle();
        next_cycle();
        for (int c = 0; c < 4; c++) next_cycle();
        @(negedge clk);
        vectors++;
        if ({state, trap, trap_code, d_req} !== {3'd7, 1'b1, 2'b10, 1'b0}) begin
            miscompares++;
            $display("FAIL dwd_trap: got %b want 1111100", {state, trap, trap_code, d_req});
        end
    endtask

    task automatic test_illegal_and_recovery();
        do_reset();
        opcode = 6'b111111; i_ack = 1'b1;
        next_cycle(); i_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if ({state, trap} !== {3'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL ill_decode: got st=%0d trap=%b want st=1 trap=0", state, trap);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({state, trap, trap_code} !== {3'd7, 1'b1, 2'b11}) begin
            miscompares++;
            $display("FAIL ill_trap: got %b want 111111", {state, trap, trap_code});
        end
        do_reset();
        @(negedge clk);
        vectors++;
        if ({state, trap, trap_code, i_req} !== {3'd0, 1'b0, 2'b00, 1'b1}) begin
            miscompares++;
            $display("FAIL trap_clear: got %b want 0000001", {state, trap, trap_code, i_req});
        end
        opcode = 6'b101011; i_ack = 1'b1;
        next_cycle(); i_ack = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({state, d_req} !== {3'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL rst_mem_pre: got st=%0d dreq=%b want st=3 dreq=1", state, d_req);
        end
        rst = 1'b1; d_ack = 1'b1;
        #1;
        vectors++;
        if (all_outs !== 21'd0) begin
            miscompares++;
            $display("FAIL rst_mem_drop: got %h want 000000", all_outs);
        end
        next_cycle();
        rst = 1'b0; d_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if ({state, i_req, retire, d_req} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_mem_restart: got %b want 000100", {state, i_req, retire, d_req});
        end
    endtask

    initial begin
        rst = 1'b1; opcode = '0; zero = 1'b0; i_ack = 1'b0; d_ack = 1'b0;
        #1;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw();
        test_branches();
        test_jump();
        test_fetch_watchdog();
        test_data_watchdog();
        test_illegal_and_recovery();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
